// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_unit_pkg
//  Purpose  : Shared constants and the fetch state type for the PC / fetch
//             unit (PC-select codes, canonical NOP, fetch FSM states).
//  Revision : 1.0  initial release
// ============================================================================
package pc_fetch_unit_pkg;

   // PC-select codes driven by the branch control unit
   localparam logic [1:0] PCSRC_SEQ  = 2'b00;
   localparam logic [1:0] PCSRC_BR   = 2'b01;
   localparam logic [1:0] PCSRC_HALT = 2'b10;
   localparam logic [1:0] PCSRC_JALR = 2'b11;

   // addi x0, x0, 0 -- placed in IF/ID whenever it holds no live instruction
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Fetch FSM states, 3-bit encoding
   typedef enum logic [2:0] {
      ST_REQ     = 3'd0,   // request presented on the instruction bus
      ST_WAIT    = 3'd1,   // request accepted, waiting for its response
      ST_HOLD    = 3'd2,   // response parked in the skid buffer during a stall
      ST_DISCARD = 3'd3,   // wrong-path response still outstanding, drop it
      ST_HALT    = 3'd4    // fetch stopped until reset
   } fetch_state_e;

endpackage : pc_fetch_unit_pkg
`default_nettype wire

// File: rtl/pc_fetch_unit_pc_next_mux.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next_mux
//  Purpose  : Decodes the PC-select code into sequential PC, redirect target,
//             redirect / halt requests and target misalignment.
//  Revision : 1.0  initial release
// ============================================================================
module pc_next_mux
   import pc_fetch_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc_i,
   input  logic [1:0]      pc_src_i,
   input  logic [XLEN-1:0] branch_target_i,
   input  logic [XLEN-1:0] jalr_target_i,
   output logic [XLEN-1:0] pc_seq_o,
   output logic [XLEN-1:0] target_o,
   output logic            redirect_o,
   output logic            halt_o,
   output logic            misalign_o
);

   logic is_jump;

   // Target select and classification; a misaligned jump stops fetch like a halt
   always_comb begin
      pc_seq_o   = pc_i + XLEN'(4);
      target_o   = branch_target_i;
      is_jump    = 1'b0;
      redirect_o = 1'b0;
      halt_o     = 1'b0;
      misalign_o = 1'b0;
      case (pc_src_i)
         PCSRC_BR: begin
            is_jump  = 1'b1;
            target_o = branch_target_i;
         end
         PCSRC_JALR: begin
            is_jump  = 1'b1;
            target_o = {jalr_target_i[XLEN-1:1], 1'b0};
         end
         PCSRC_HALT: halt_o = 1'b1;
         default:    ;
      endcase
      if (is_jump) begin
         misalign_o = target_o[1];
         redirect_o = !target_o[1];
         halt_o     = target_o[1];
      end
   end

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_unit
//  Purpose  : Owns the program counter, issues single-outstanding instruction
//             fetches and drives the IF/ID register, handling redirects,
//             stalls, halts and wrong-path response draining.
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      pc_src_i,
   input  logic [XLEN-1:0] branch_target_i,
   input  logic [XLEN-1:0] jalr_target_i,
   input  logic            stall_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ready_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   output logic            if_valid_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic [31:0]     if_instr_o,
   output logic            flush_o,
   output logic            misalign_o,
   output logic            halted_o
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            halt_pend_q, halt_pend_d;
   logic [31:0]     skid_q, skid_d;
   logic            if_valid_q, if_valid_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic [31:0]     if_instr_q, if_instr_d;

   logic [XLEN-1:0] pc_seq;
   logic [XLEN-1:0] target;
   logic            redirect;
   logic            halt_req;
   logic            misalign_req;

   logic            active;
   logic            kill;
   logic            accept;
   logic            drain;
   logic            load;
   logic [31:0]     load_instr;

   pc_next_mux #(
      .XLEN (XLEN)
   ) u_next_mux (
      .pc_i            (pc_q),
      .pc_src_i        (pc_src_i),
      .branch_target_i (branch_target_i),
      .jalr_target_i   (jalr_target_i),
      .pc_seq_o        (pc_seq),
      .target_o        (target),
      .redirect_o      (redirect),
      .halt_o          (halt_req),
      .misalign_o      (misalign_req)
   );

   // Once fetch is stopped (or a stop is waiting for a drain) pc_src is ignored
   assign active = (state_q != ST_HALT) && !halt_pend_q;
   assign kill   = active && (redirect || halt_req);
   assign accept = (state_q == ST_REQ) && imem_ready_i;

   // Next-state logic: redirect/halt first, otherwise the fetch handshake
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      halt_pend_d = halt_pend_q;
      skid_d      = skid_q;
      if_valid_d  = if_valid_q;
      if_pc_d     = if_pc_q;
      if_instr_d  = if_instr_q;
      drain       = 1'b0;
      load        = 1'b0;
      load_instr  = imem_rdata_i;

      if (kill) begin
         // A response is still owed if one was just accepted or is pending
         // and does not arrive in this very cycle.
         drain = accept ||
                 (((state_q == ST_WAIT) || (state_q == ST_DISCARD)) && !imem_rvalid_i);
         if_valid_d = 1'b0;
         if_instr_d = NOP_INSTR;
         if (halt_req) begin
            halt_pend_d = drain;
            state_d     = drain ? ST_DISCARD : ST_HALT;
         end else begin
            pc_d    = target;
            state_d = drain ? ST_DISCARD : ST_REQ;
         end
      end else begin
         case (state_q)
            ST_REQ: begin
               if (accept) state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_rvalid_i) begin
                  if (stall_i) begin
                     skid_d  = imem_rdata_i;
                     state_d = ST_HOLD;
                  end else begin
                     load    = 1'b1;
                     state_d = ST_REQ;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall_i) begin
                  load       = 1'b1;
                  load_instr = skid_q;
                  state_d    = ST_REQ;
               end
            end
            ST_DISCARD: begin
               if (imem_rvalid_i) begin
                  state_d     = halt_pend_q ? ST_HALT : ST_REQ;
                  halt_pend_d = 1'b0;
               end
            end
            ST_HALT: ;
            default: state_d = ST_REQ;
         endcase

         // ID consumes IF/ID every unstalled cycle; refill or insert a bubble
         if (load) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = load_instr;
            pc_d       = pc_seq;
         end else if (!stall_i) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
         end
      end
   end

   // State, PC, skid buffer and IF/ID registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_REQ;
         pc_q        <= RESET_PC;
         halt_pend_q <= 1'b0;
         skid_q      <= '0;
         if_valid_q  <= 1'b0;
         if_pc_q     <= '0;
         if_instr_q  <= NOP_INSTR;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         halt_pend_q <= halt_pend_d;
         skid_q      <= skid_d;
         if_valid_q  <= if_valid_d;
         if_pc_q     <= if_pc_d;
         if_instr_q  <= if_instr_d;
      end
   end

   // Request and kill pulses are decoded in the current cycle so the
   // downstream pipeline is flushed in the same cycle the redirect is seen;
   // all are forced low while reset is asserted.
   assign imem_req_o  = rst_n && (state_q == ST_REQ);
   assign imem_addr_o = pc_q;
   assign flush_o     = rst_n && kill;
   assign misalign_o  = rst_n && active && misalign_req;
   assign halted_o    = (state_q == ST_HALT) || halt_pend_q;
   assign if_valid_o  = if_valid_q;
   assign if_pc_o     = if_pc_q;
   assign if_instr_o  = if_instr_q;

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_unit
//  Purpose  : Randomised self-checking bench for pc_fetch_unit against a
//             transaction-level model of fetch, redirect, stall and halt.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

   localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;   // wraps after two fetches
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          NCYC   = 4000;

   logic        clk;
   logic        rst_n;
   logic [1:0]  pc_src;
   logic [31:0] branch_target;
   logic [31:0] jalr_target;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        flush;
   logic        misalign;
   logic        halted;

   int n_cmp = 0;
   int n_bad = 0;

   pc_fetch_unit #(
      .XLEN     (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pc_src_i        (pc_src),
      .branch_target_i (branch_target),
      .jalr_target_i   (jalr_target),
      .stall_i         (stall),
      .imem_req_o      (imem_req),
      .imem_addr_o     (imem_addr),
      .imem_ready_i    (imem_ready),
      .imem_rvalid_i   (imem_rvalid),
      .imem_rdata_i    (imem_rdata),
      .if_valid_o      (if_valid),
      .if_pc_o         (if_pc),
      .if_instr_o      (if_instr),
      .flush_o         (flush),
      .misalign_o      (misalign),
      .halted_o        (halted)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: what is in flight, where fetch goes next, what ID sees
   logic [31:0] m_pc, m_skid, m_ifpc, m_ifinstr;
   bit          m_busy, m_junk, m_skv, m_stop, m_drain_stop, m_ifv;
   // Memory responder
   bit          mem_pend;
   int          mem_cnt;
   logic [31:0] mem_data;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_skid = '0; m_ifpc = '0; m_ifinstr = NOP;
      m_busy = 0; m_junk = 0; m_skv = 0; m_stop = 0; m_drain_stop = 0; m_ifv = 0;
      mem_pend = 0; mem_cnt = 0; mem_data = '0;
   endtask

   task automatic check_regs();
      check_eq("if_valid", {31'b0, if_valid}, {31'b0, m_ifv});
      check_eq("if_pc",    if_pc,    m_ifpc);
      check_eq("if_instr", if_instr, m_ifinstr);
      check_eq("halted",   {31'b0, halted}, {31'b0, (m_stop || m_drain_stop)});
   endtask

   // Reset asserted between edges: outputs must drop at once
   task automatic async_reset();
      #2;
      pc_src = 2'b01; branch_target = 32'h40; stall = 0;
      imem_ready = 1; imem_rvalid = 0;
      rst_n = 0;
      #1;
      check_eq("rst_req",      {31'b0, imem_req}, 32'd0);
      check_eq("rst_if_valid", {31'b0, if_valid}, 32'd0);
      check_eq("rst_if_pc",    if_pc,    32'd0);
      check_eq("rst_if_instr", if_instr, NOP);
      check_eq("rst_flush",    {31'b0, flush},    32'd0);
      check_eq("rst_misalign", {31'b0, misalign}, 32'd0);
      check_eq("rst_halted",   {31'b0, halted},   32'd0);
      @(negedge clk);
      rst_n = 1;
      model_reset();
   endtask

   initial begin
      logic [31:0] tgt, dval;
      bit live, is_redir, bad, exp_req, exp_flush, exp_mis, accept, got_resp, inflight, delivered;
      int stop_cycles, r;

      rst_n = 0; pc_src = 0; branch_target = 0; jalr_target = 0; stall = 0;
      imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
      model_reset();
      stop_cycles = 0;
      repeat (2) @(negedge clk);
      check_eq("reset_req", {31'b0, imem_req}, 32'd0);
      rst_n = 1;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         check_regs();

         stop_cycles = m_stop ? stop_cycles + 1 : 0;
         if (stop_cycles > 3 || ($urandom % 300) == 0) begin
            async_reset();
            stop_cycles = 0;
            continue;
         end

         // Memory response for this cycle
         imem_rvalid = 0;
         imem_rdata  = $urandom;
         if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               imem_rvalid = 1;
               imem_rdata  = mem_data;
               mem_pend    = 0;
            end
         end

         // Random control stimulus
         imem_ready = ($urandom % 4) != 0;
         stall      = ($urandom % 4) == 0;
         r = $urandom % 100;
         pc_src = (r < 6) ? 2'b01 : (r < 10) ? 2'b11 : (r < 11) ? 2'b10 : 2'b00;
         branch_target = ($urandom & 32'h0000_03FC) | ((($urandom % 8) == 0) ? 32'h2 : 32'h0);
         jalr_target   = ($urandom & 32'h0000_03FD) | ((($urandom % 8) == 0) ? 32'h2 : 32'h0);

         // Expected combinational outputs
         live      = !m_stop && !m_drain_stop;
         is_redir  = (pc_src == 2'b01) || (pc_src == 2'b11);
         tgt       = (pc_src == 2'b11) ? (jalr_target & ~32'h1) : branch_target;
         bad       = is_redir && tgt[1];
         exp_flush = live && (pc_src != 2'b00);
         exp_mis   = live && bad;
         exp_req   = live && !m_busy && !m_skv;
         #1;
         check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
         if (exp_req) check_eq("imem_addr", imem_addr, m_pc);
         check_eq("flush",    {31'b0, flush},    {31'b0, exp_flush});
         check_eq("misalign", {31'b0, misalign}, {31'b0, exp_mis});

         // Advance the model across the coming clock edge
         accept   = exp_req && imem_ready;
         got_resp = m_busy && imem_rvalid;
         if (!live) begin
            if (m_drain_stop && got_resp) begin
               m_busy = 0; m_drain_stop = 0; m_stop = 1;
            end
         end else if (pc_src != 2'b00) begin
            inflight = (m_busy && !imem_rvalid) || accept;
            m_busy = inflight; m_junk = inflight; m_skv = 0;
            m_ifv = 0; m_ifinstr = NOP;
            if (!is_redir || bad) begin
               if (inflight) m_drain_stop = 1;
               else          m_stop = 1;
            end else begin
               m_pc = tgt;
            end
         end else begin
            delivered = 0;
            dval      = '0;
            if (got_resp) begin
               m_busy = 0;
               if (!m_junk) begin
                  if (stall) begin
                     m_skv = 1; m_skid = imem_rdata;
                  end else begin
                     delivered = 1; dval = imem_rdata;
                  end
               end
               m_junk = 0;
            end else if (m_skv && !stall) begin
               m_skv = 0; delivered = 1; dval = m_skid;
            end
            if (accept) begin
               m_busy = 1; m_junk = 0;
            end
            if (delivered) begin
               m_ifv = 1; m_ifpc = m_pc; m_ifinstr = dval; m_pc = m_pc + 32'd4;
            end else if (!stall) begin
               m_ifv = 0; m_ifinstr = NOP;
            end
         end

         if (accept) begin
            mem_pend = 1;
            mem_cnt  = $urandom_range(1, 3);
            mem_data = $urandom;
         end

         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_pc_fetch_unit
`default_nettype wire
